// File: rtl/gpsreceiver2_tx.sv
// Plays buffer bytes out as an SE4162T-style serial stream (lo nibble first, LSB first), first tx-clock rise clk_div+3 cycles after start.
// No backpressure: the buffer is read with fixed one-cycle latency, and the next byte is prefetched during bit 7.
module gpsreceiver2_tx #(
    parameter int ADR_WIDTH = 11
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop,
    input  logic [ADR_WIDTH-1:0] length,
    input  logic [7:0]           clk_div,
    output logic [ADR_WIDTH-1:0] txb_adr,
    input  logic [7:0]           txb_dat,
    output logic                 gps_tx_clk,
    output logic                 gps_tx_data,
    output logic                 gps_tx_sync,
    output logic                 busy,
    output logic                 done
);

    typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

    localparam logic [ADR_WIDTH-1:0] ADR_ONE = {{(ADR_WIDTH-1){1'b0}}, 1'b1};

    state_t               state;
    logic [ADR_WIDTH-1:0] len_q;
    logic [7:0]           div_q;
    logic [7:0]           div_cnt;
    logic [7:0]           byte_q;
    logic [2:0]           bit_cnt;
    logic [2:0]           nxt_bit;
    logic                 fwait;
    logic                 stop_pend;
    logic                 last_end;

    assign nxt_bit = bit_cnt + 3'd1;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            len_q       <= '0;
            div_q       <= '0;
            div_cnt     <= '0;
            byte_q      <= '0;
            bit_cnt     <= '0;
            fwait       <= 1'b0;
            stop_pend   <= 1'b0;
            last_end    <= 1'b0;
            txb_adr     <= '0;
            gps_tx_clk  <= 1'b0;
            gps_tx_data <= 1'b0;
            gps_tx_sync <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q     <= length;
                        div_q     <= clk_div;
                        txb_adr   <= '0;
                        stop_pend <= 1'b0;
                        fwait     <= 1'b0;
                        last_end  <= 1'b0;
                        if (length == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                            busy  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (stop) stop_pend <= 1'b1;
                    // txb_dat only reflects address 0 on the second cycle here
                    if (!fwait) begin
                        fwait <= 1'b1;
                    end else begin
                        state       <= SHIFT;
                        byte_q      <= txb_dat;
                        gps_tx_clk  <= 1'b0;
                        gps_tx_data <= txb_dat[0];
                        gps_tx_sync <= 1'b1;
                        bit_cnt     <= '0;
                        div_cnt     <= '0;
                    end
                end
                SHIFT: begin
                    if (stop) stop_pend <= 1'b1;
                    if (div_cnt != div_q) begin
                        div_cnt <= div_cnt + 8'd1;
                    end else begin
                        div_cnt <= '0;
                        if (!gps_tx_clk) begin
                            gps_tx_clk <= 1'b1;
                        end else if (bit_cnt == 3'd7) begin
                            gps_tx_clk <= 1'b0;
                            if (last_end || stop_pend || stop) begin
                                state       <= DONE;
                                done        <= 1'b1;
                                busy        <= 1'b0;
                                gps_tx_data <= 1'b0;
                                gps_tx_sync <= 1'b0;
                                stop_pend   <= 1'b0;
                            end else begin
                                byte_q      <= txb_dat;
                                gps_tx_data <= txb_dat[0];
                                gps_tx_sync <= 1'b1;
                                bit_cnt     <= '0;
                            end
                        end else begin
                            gps_tx_clk  <= 1'b0;
                            bit_cnt     <= nxt_bit;
                            gps_tx_data <= byte_q[nxt_bit];
                            gps_tx_sync <= (nxt_bit == 3'd4);
                            // Prefetch next byte so it is ready at the end of bit 7
                            if (nxt_bit == 3'd7) begin
                                if (txb_adr == len_q - ADR_ONE) begin
                                    last_end <= !loop;
                                    if (loop) txb_adr <= '0;
                                end else begin
                                    txb_adr  <= txb_adr + ADR_ONE;
                                    last_end <= 1'b0;
                                end
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gpsreceiver2_tx.md
GPSRECEIVER2_TX -- requirements
Module: gpsreceiver2_tx

Interface
REQ-001 Parameter: ADR_WIDTH, default 11, buffer address and byte-count width.
REQ-002 sys_clk  input  1  single clock; all logic on rising edge.
REQ-003 sys_rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle pulse; begin playback from buffer address 0.
REQ-005 stop  input  1  one-cycle pulse; end playback at next byte boundary.
REQ-006 loop  input  1  1 = restart at address 0 after last byte.
REQ-007 length  input  ADR_WIDTH  bytes to play; sampled on accepted start.
REQ-008 clk_div  input  8  serial half-period minus one, in sys_clk cycles; sampled on accepted start.
REQ-009 txb_adr  output  ADR_WIDTH  sample buffer read address.
REQ-010 txb_dat  input  8  buffer read data; valid exactly one sys_clk after txb_adr.
REQ-011 gps_tx_clk  output  1  emulated front-end sample clock.
REQ-012 gps_tx_data  output  1  serial IQ data (SMSM nibble format).
REQ-013 gps_tx_sync  output  1  nibble sync, high during first bit of each nibble.
REQ-014 busy  output  1  high from accepted start until playback ends.
REQ-015 done  output  1  one-cycle pulse when playback ends.

Function
REQ-016 Function: serializes buffer bytes into the SE4162T-style stream the receiver captures; byte = {hi,lo}, lo nibble first, each nibble LSB first.
REQ-017 Bit period: 2*(clk_div+1) sys_clk cycles; gps_tx_clk low for first clk_div+1 cycles, high for remaining clk_div+1.
REQ-018 gps_tx_data and gps_tx_sync change only on the sys_clk edge where gps_tx_clk goes low (falling edge), stable through its rising edge.
REQ-019 gps_tx_sync high for bit 0 and bit 4 of each byte, low for bits 1-3 and 5-7.
REQ-020 FSM states: IDLE, FETCH, SHIFT, DONE.
REQ-021 IDLE: outputs gps_tx_clk=0, gps_tx_data=0, gps_tx_sync=0, busy=0; start -> FETCH with txb_adr=0, or -> DONE if length=0.
REQ-022 FETCH: one-cycle wait for txb_dat; latch into shift register -> SHIFT; first bit driven on FETCH exit edge.
REQ-023 SHIFT: 8 bits per byte; next byte address issued and data prefetched during bit 7 so consecutive bytes have no gap.
REQ-024 End of byte (txb_adr = length-1) with loop=0 -> DONE; with loop=1 -> continue seamlessly from address 0.
REQ-025 Stop pending at byte end -> DONE regardless of loop; stop never truncates a byte; stop in IDLE ignored.
REQ-026 DONE: single cycle, done=1, busy=0, outputs returned to idle values -> IDLE.
REQ-027 start while busy ignored; length/clk_div changes while busy have no effect.
REQ-028 start and stop in same IDLE cycle: start wins, stop discarded.
REQ-029 txb_adr increments modulo 2^ADR_WIDTH; length=0 plays zero bytes; length upper bound 2^ADR_WIDTH-1.
REQ-030 Latency: first gps_tx_clk rising edge occurs clk_div+3 sys_clk cycles after start.

Reset
REQ-031 sys_rst forces IDLE, txb_adr=0, gps_tx_clk=0, gps_tx_data=0, gps_tx_sync=0, busy=0, done=0, pending stop cleared.
REQ-032 sys_rst mid-byte aborts immediately; no done pulse issued.

Verification
REQ-033 Buffer[0]=0xA5, length=1, clk_div=0, start -> data bits 1,0,1,0,0,1,0,1, sync 1,0,0,0,1,0,0,0, 16 bits of gps_tx_clk toggling at sys_clk/2, done after bit 7.
REQ-034 Buffer 0x00..0x03, length=4, clk_div=3 -> 32 contiguous bits, 8 sys_clk per bit, no gap between bytes; txb_adr sequence 0,1,2,3.
REQ-035 length=2, loop=1, stop asserted mid-byte 5 -> bytes 0,1,0,1,0,1 fully sent, done pulse, busy=0.
REQ-036 length=0, start -> done one cycle later, no gps_tx_clk edges.
REQ-037 sys_rst during bit 3 of byte 0 -> next cycle all outputs 0, no done; fresh start replays from byte 0.
REQ-038 Loopback into receiver: clock gpsreceiver2_rx from gps_tx_clk/gps_tx_data/gps_tx_sync -> captured bytes equal buffer contents.
